// File: rtl/regfile_pkg.sv
// Shared constants for the 2-read/1-write datapath register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_if.sv
// Bus bundle between the decode stage (master) and the register file (slave).
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              we;
  logic              reg_dst;
  logic [ADDR_W-1:0] write0_addr;
  logic [ADDR_W-1:0] write1_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read0_addr;
  logic [ADDR_W-1:0] read1_addr;
  logic [DATA_W-1:0] read0_data;
  logic [DATA_W-1:0] read1_data;

  modport master (
    output we, reg_dst, write0_addr, write1_addr, write_data,
    output read0_addr, read1_addr,
    input  read0_data, read1_data
  );

  modport slave (
    input  we, reg_dst, write0_addr, write1_addr, write_data,
    input  read0_addr, read1_addr,
    output read0_data, read1_data
  );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: r0 reads as zero, a same-edge write to the
// addressed register is forwarded, otherwise the stored value is returned.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                                 clk,
  input  logic                                 rst_all,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   mem,
  input  logic [ADDR_W-1:0]                    raddr,
  input  logic                                 we,
  input  logic [ADDR_W-1:0]                    waddr,
  input  logic [DATA_W-1:0]                    write_data,
  output logic [DATA_W-1:0]                    rdata
);

  // The zero check is ahead of the bypass so a discarded r0 write never leaks.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      rdata <= '0;
    end else if (raddr == ADDR_W'(ZERO_REG)) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= write_data;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 register file with two registered read ports, one write port and
// a reg_dst-selected write address.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic       clk,
  input logic       rst_all,
  regfile_if.slave  bus
);

  localparam int ENTRIES = 2**ADDR_W;

  logic [ENTRIES-1:0][DATA_W-1:0] mem;
  logic [ADDR_W-1:0]              waddr;
  logic                           wcommit;

  assign waddr   = bus.reg_dst ? bus.write1_addr : bus.write0_addr;
  assign wcommit = bus.we && (waddr != ADDR_W'(ZERO_REG));

  // Reset wins over a write on the same edge; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      mem <= '0;
    end else if (wcommit) begin
      mem[waddr] <= bus.write_data;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read0 (
    .clk        (clk),
    .rst_all    (rst_all),
    .mem        (mem),
    .raddr      (bus.read0_addr),
    .we         (bus.we),
    .waddr      (waddr),
    .write_data (bus.write_data),
    .rdata      (bus.read0_data)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read1 (
    .clk        (clk),
    .rst_all    (rst_all),
    .mem        (mem),
    .raddr      (bus.read1_addr),
    .we         (bus.we),
    .waddr      (waddr),
    .write_data (bus.write_data),
    .rdata      (bus.read1_data)
  );

endmodule
